// File: rtl/gemm_drain_pkg.sv
// Shared state encoding and row-major address helper for the GEMM C-tile drain.
// Latency: none (types and a pure function). Backpressure: none.
package gemm_drain_pkg;

   localparam int CalcWidth = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TILE,
      DRAIN,
      DONE
   } drain_state_e;

   // Address of element (r,c) of tile (tm,tn); m/n are the tile dimensions.
   function automatic logic [CalcWidth-1:0] elem_addr(
      input logic [CalcWidth-1:0] tm,
      input logic [CalcWidth-1:0] tn,
      input logic [CalcWidth-1:0] r,
      input logic [CalcWidth-1:0] c,
      input logic [CalcWidth-1:0] n_size,
      input logic [CalcWidth-1:0] m = 32'd4,
      input logic [CalcWidth-1:0] n = 32'd4
   );
      return (tm * m + r) * n_size + tn * n + c;
   endfunction

endpackage

// File: rtl/gemm_c_tile_drain_buf.sv
// M x N element register buffer: whole-tile load, combinational (r,c) read.
// Latency: load visible the cycle after load_i. Backpressure: none, caller owns load timing.
module gemm_tile_buf #(
   parameter int DataWidth = 32,
   parameter int M         = 4,
   parameter int N         = 4,
   parameter int RowWidth  = 2,
   parameter int ColWidth  = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       load_i,
   input  logic [DataWidth*M*N-1:0]   data_i,
   input  logic [RowWidth-1:0]        r_i,
   input  logic [ColWidth-1:0]        c_i,
   output logic [DataWidth-1:0]       rdata_o
);

   localparam int IdxWidth = (M * N > 1) ? $clog2(M * N) : 1;

   logic [M*N-1:0][DataWidth-1:0] data_q;
   logic [IdxWidth-1:0]           idx;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= data_i;
      end
   end

   assign idx     = IdxWidth'(int'(r_i) * N + int'(c_i));
   assign rdata_o = data_q[idx];

endmodule

// File: rtl/gemm_c_tile_drain.sv
// Serialises packed M x N int32 tiles into row-major single-element writes; first write the cycle after accept.
// Stalls while out_ready_i=0; tile_ready_o only in WAIT_TILE (GEMM_C_DRAIN_SKID_EN: also in DRAIN while the spare buffer is free).
module gemm_c_tile_drain
   import gemm_drain_pkg::*;
#(
   parameter int OutDataWidth  = 32,
   parameter int M             = 4,
   parameter int N             = 4,
   parameter int SizeAddrWidth = 8,
   parameter int OutAddrWidth  = 12
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           start_i,
   input  logic [SizeAddrWidth-1:0]       M_size_i,
   input  logic [SizeAddrWidth-1:0]       N_size_i,
   input  logic                           tile_valid_i,
   output logic                           tile_ready_o,
   input  logic [OutDataWidth*M*N-1:0]    tile_data_i,
   input  logic                           out_ready_i,
   output logic                           out_we_o,
   output logic [OutAddrWidth-1:0]        out_addr_o,
   output logic [OutDataWidth-1:0]        out_wdata_o,
   output logic                           done_o
);

   localparam int RowWidth = (M > 1) ? $clog2(M) : 1;
   localparam int ColWidth = (N > 1) ? $clog2(N) : 1;

   drain_state_e state_q, state_d;

   logic [SizeAddrWidth-1:0] tiles_m_q, tiles_n_q, n_size_q, tm_q, tn_q;
   logic [SizeAddrWidth-1:0] tiles_m_d, tiles_n_d;
   logic [RowWidth-1:0]      r_q;
   logic [ColWidth-1:0]      c_q;

   logic accept, elem_done, tile_end, last_tile, swap, rdy_drain, load_a;
   logic [OutDataWidth-1:0] rdata_a;

   assign tiles_m_d = SizeAddrWidth'(M_size_i / SizeAddrWidth'(M));
   assign tiles_n_d = SizeAddrWidth'(N_size_i / SizeAddrWidth'(N));

   assign accept    = tile_valid_i & tile_ready_o;
   assign elem_done = (state_q == DRAIN) & out_ready_i;
   assign tile_end  = elem_done & (r_q == RowWidth'(M - 1)) & (c_q == ColWidth'(N - 1));
   assign last_tile = (tm_q == tiles_m_q - SizeAddrWidth'(1)) &
                      (tn_q == tiles_n_q - SizeAddrWidth'(1));

   gemm_tile_buf #(
      .DataWidth (OutDataWidth),
      .M         (M),
      .N         (N),
      .RowWidth  (RowWidth),
      .ColWidth  (ColWidth)
   ) u_buf_a (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load_a),
      .data_i  (tile_data_i),
      .r_i     (r_q),
      .c_i     (c_q),
      .rdata_o (rdata_a)
   );

`ifdef GEMM_C_DRAIN_SKID_EN
   // Ping-pong pair: act_q selects the draining buffer, pend_q marks a tile waiting in the other one.
   logic act_q, pend_q, load_b;
   logic [OutDataWidth-1:0] rdata_b;

   assign swap      = tile_end & ~last_tile & (pend_q | accept);
   assign rdy_drain = ~pend_q & ~last_tile;
   assign load_a    = accept & ((state_q == WAIT_TILE) ? ~act_q : act_q);
   assign load_b    = accept & ((state_q == WAIT_TILE) ? act_q : ~act_q);
   assign out_wdata_o = act_q ? rdata_b : rdata_a;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         act_q  <= 1'b0;
         pend_q <= 1'b0;
      end else if (swap) begin
         act_q  <= ~act_q;
         pend_q <= 1'b0;
      end else if (accept && state_q == DRAIN) begin
         pend_q <= 1'b1;
      end
   end

   gemm_tile_buf #(
      .DataWidth (OutDataWidth),
      .M         (M),
      .N         (N),
      .RowWidth  (RowWidth),
      .ColWidth  (ColWidth)
   ) u_buf_b (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load_b),
      .data_i  (tile_data_i),
      .r_i     (r_q),
      .c_i     (c_q),
      .rdata_o (rdata_b)
   );
`else
   assign swap        = 1'b0;
   assign rdy_drain   = 1'b0;
   assign load_a      = accept;
   assign out_wdata_o = rdata_a;
`endif

   // Address is a pure function of registered counters, so no input reaches out_addr_o.
   assign out_addr_o = OutAddrWidth'(elem_addr(CalcWidth'(tm_q), CalcWidth'(tn_q),
                                               CalcWidth'(r_q), CalcWidth'(c_q),
                                               CalcWidth'(n_size_q),
                                               CalcWidth'(M), CalcWidth'(N)));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = (tiles_m_d == '0 || tiles_n_d == '0) ? DONE : WAIT_TILE;
            end
         end
         WAIT_TILE: begin
            if (tile_valid_i) state_d = DRAIN;
         end
         DRAIN: begin
            if (tile_end) state_d = last_tile ? DONE : (swap ? DRAIN : WAIT_TILE);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tile_ready_o = 1'b0;
      out_we_o     = 1'b0;
      done_o       = 1'b0;
      unique case (state_q)
         WAIT_TILE: tile_ready_o = 1'b1;
         DRAIN: begin
            out_we_o     = out_ready_i;
            tile_ready_o = rdy_drain;
         end
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tiles_m_q <= '0;
         tiles_n_q <= '0;
         n_size_q  <= '0;
         tm_q      <= '0;
         tn_q      <= '0;
         r_q       <= '0;
         c_q       <= '0;
      end else begin
         if (state_q == IDLE && start_i) begin
            tiles_m_q <= tiles_m_d;
            tiles_n_q <= tiles_n_d;
            n_size_q  <= N_size_i;
            tm_q      <= '0;
            tn_q      <= '0;
         end
         if (state_q == WAIT_TILE && tile_valid_i) begin
            r_q <= '0;
            c_q <= '0;
         end
         if (elem_done) begin
            if (c_q == ColWidth'(N - 1)) begin
               c_q <= '0;
               if (r_q == RowWidth'(M - 1)) begin
                  r_q <= '0;
                  if (tn_q == tiles_n_q - SizeAddrWidth'(1)) begin
                     tn_q <= '0;
                     tm_q <= tm_q + SizeAddrWidth'(1);
                  end else begin
                     tn_q <= tn_q + SizeAddrWidth'(1);
                  end
               end else begin
                  r_q <= r_q + RowWidth'(1);
               end
            end else begin
               c_q <= c_q + ColWidth'(1);
            end
         end
      end
   end

endmodule

// File: doc/gemm_c_tile_drain.md
# gemm_c_tile_drain

Output-side writeback stage that sits directly downstream of `gemm_accelerator_top`.
- It accepts packed M×N tiles of int32 results, one tile per handshake, in tile-row-major order.
- It serialises each tile into single-element writes to a 32-bit row-major result memory, so matrix C lands in plain row-major layout.
- It tracks tile position internally and raises `done_o` after the final element of an M_size×N_size result.

## Interface
Parameters:
- `OutDataWidth`, 32: width of one result element.
- `M`, 4: tile rows.
- `N`, 4: tile columns.
- `SizeAddrWidth`, 8: width of the matrix-size inputs.
- `OutAddrWidth`, 12: element address width of the result memory.

Ports (the clock is `clk_i`; reset `rst_ni` is asynchronous and active-low):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  async active-low reset.
- `start_i`  in  1  latches sizes and arms the drain; honoured only in IDLE.
- `M_size_i`  in  SizeAddrWidth  result rows.
- `N_size_i`  in  SizeAddrWidth  result columns.
- `tile_valid_i`  in  1  tile present.
- `tile_ready_o`  out  1  tile can be accepted.
- `tile_data_i`  in  OutDataWidth*M*N  tile; element (r,c) sits at bits [(r*N+c)*OutDataWidth +: OutDataWidth].
- `out_ready_i`  in  1  result memory accepts a write this cycle.
- `out_we_o`  out  1  element write strobe.
- `out_addr_o`  out  OutAddrWidth  element address.
- `out_wdata_o`  out  OutDataWidth  element value.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, WAIT_TILE, DRAIN, DONE.
- IDLE, on `start_i`:
  - Latch `tiles_m = M_size_i / M` and `tiles_n = N_size_i / N` (integer division; a remainder is dropped).
  - Latch `N_size_i`.
  - Clear tile counters `tm` and `tn`.
  - If `tiles_m` or `tiles_n` is 0, go to DONE; otherwise go to WAIT_TILE.
- WAIT_TILE: `tile_ready_o`=1. On `tile_valid_i`, copy `tile_data_i` into the tile buffer, clear element counters r and c, and go to DRAIN.
- DRAIN:
  - `out_we_o` equals `out_ready_i`.
  - `out_addr_o = (tm*M + r)*N_size + tn*N + c`, truncated to OutAddrWidth.
  - `out_wdata_o` = buffer element (r,c).
  - Advance c, then r, only on cycles where `out_ready_i`=1.
  - When a write at (M-1,N-1) completes, advance tn. If tn wraps, clear tn and advance tm.
  - If that was the last tile (`tm`=`tiles_m`-1 and `tn`=`tiles_n`-1), go to DONE; otherwise go to WAIT_TILE.
- DONE: `done_o`=1 for exactly one cycle, then return to IDLE.
- `start_i` outside IDLE is ignored. `tile_valid_i` outside WAIT_TILE is not accepted and the tile must be held by the producer.
- Address arithmetic uses at least 2*SizeAddrWidth bits internally before truncation.

## Timing
- Reset values: `tile_ready_o`=0, `out_we_o`=0, `out_addr_o`=0, `out_wdata_o`=0, `done_o`=0, state=IDLE, all counters 0.
- Reset asserted mid-operation aborts immediately and discards the buffered tile. There is no partial-write recovery.
- Tile accepted at edge t → first write presented in cycle t+1.
- With `out_ready_i` held high, the 16 writes occupy cycles t+1 to t+16 (for M=N=4).
- Base throughput is M*N+1 cycles per tile: the accept cycle plus M*N write cycles.
- `done_o` asserts in the cycle after the last write.
- Outputs are registered; there is no combinational path from `tile_valid_i` to `out_*`.
- `out_ready_i`=0 stalls the counters. `out_addr_o` and `out_wdata_o` hold steady while stalled and `out_we_o`=0.

## Configuration
- `GEMM_C_DRAIN_SKID_EN` defined: adds a second tile buffer.
  - `tile_ready_o` is also high in DRAIN while the second buffer is empty.
  - A tile accepted during DRAIN is swapped in on the cycle the last element of the current tile is written, with no WAIT_TILE bubble.
  - Sustained throughput is M*N cycles per tile.
- Undefined: single buffer; behaviour exactly as described in Operation and Timing.

## Structure
- Package `gemm_drain_pkg`: state enum `drain_state_e`, and a function `elem_addr(tm, tn, r, c, n_size)` shared with the bench's golden model.
- One sub-module, `gemm_tile_buf`: holds the M*N element register buffer, with a load port and an (r,c) read mux. It is instantiated twice under `GEMM_C_DRAIN_SKID_EN`.
- Everything else lives in the top module.

## Test plan
- 4×4 result, one tile of elements 0..15, `out_ready_i`=1 → addresses 0..15 carry values 0..15 in cycles t+1 to t+16; `done_o` at t+17.
- 8×8 result, four tiles accepted in order → tile (1,0) element (0,0) is written to address 32, and tile (0,1) element (3,3) to address 31; 64 writes total and a single `done_o`.
- `out_ready_i` toggling 1,0,1,0 during DRAIN → no address is skipped or duplicated, and values are stable during stall cycles.
- `M_size_i`=2 → DONE straight after start, `done_o` one cycle later, no writes.
- Reset pulsed after 5 writes → all outputs at reset values. A restart then rewrites from address 0.
- With `GEMM_C_DRAIN_SKID_EN`: back-to-back valid tiles → 32 writes in 32 consecutive cycles, no idle cycle between tiles.
